// File: rtl/multdiv_unit.sv
// Multicycle signed 32-bit multiply/divide unit for the execute stage.
// Radix-4 Booth multiply (17 cycles) and magnitude restoring divide (33 cycles).
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam int MULT_LAT = 17;
  localparam int DIV_LAT  = 33;
  localparam logic [5:0] MULT_LAST = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  count;

  logic [63:0] prod, mcand, booth_term;
  logic [32:0] mplier;

  logic [32:0] a_ext, b_ext, a_mag_in, b_mag_in;
  logic [32:0] rem, b_mag;
  logic [31:0] quo, quo_signed;
  logic [33:0] trial;
  logic        neg_q, b_zero;

  // Magnitudes are taken at 33 bits so that -0x80000000 stays positive.
  always_comb begin
    a_ext    = {data_operandA[31], data_operandA};
    b_ext    = {data_operandB[31], data_operandB};
    a_mag_in = data_operandA[31] ? -a_ext : a_ext;
    b_mag_in = data_operandB[31] ? -b_ext : b_ext;
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    booth_term = '0;
    unique case (mplier[2:0])
      3'b001, 3'b010: booth_term = mcand;
      3'b011:         booth_term = mcand << 1;
      3'b100:         booth_term = -(mcand << 1);
      3'b101, 3'b110: booth_term = -mcand;
      default:        booth_term = '0;
    endcase
  end

  assign trial      = {rem, quo[31]} - {1'b0, b_mag};
  assign quo_signed = neg_q ? -quo : quo;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ctrl_MULT)     state_next = MULT;
    else if (ctrl_DIV) state_next = DIV;
    else begin
      unique case (state)
        MULT:    if (count == MULT_LAST) state_next = DONE;
        DIV:     if (count == DIV_LAST)  state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      prod           <= '0;
      mcand          <= '0;
      mplier         <= '0;
      rem            <= '0;
      b_mag          <= '0;
      quo            <= '0;
      neg_q          <= 1'b0;
      b_zero         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      count          <= '0;
      prod           <= '0;
      mcand          <= {{32{data_operandA[31]}}, data_operandA};
      mplier         <= {data_operandB, 1'b0};
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      count          <= '0;
      rem            <= {32'd0, a_mag_in[32]};
      quo            <= a_mag_in[31:0];
      b_mag          <= b_mag_in;
      neg_q          <= data_operandA[31] ^ data_operandB[31];
      b_zero         <= (data_operandB == 32'd0);
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      unique case (state)
        MULT: begin
          count <= count + 6'd1;
          if (count == MULT_LAST) begin
            data_result    <= prod[31:0];
            // Representable iff the top 33 bits are a pure sign extension.
            data_exception <= !((&prod[63:31]) || !(|prod[63:31]));
          end else begin
            prod   <= prod + booth_term;
            mcand  <= mcand << 2;
            mplier <= {{2{mplier[32]}}, mplier[32:2]};
          end
        end
        DIV: begin
          count <= count + 6'd1;
          if (count == DIV_LAST) begin
            if (b_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= quo_signed;
              data_exception <= !neg_q && quo[31];
            end
          end else if (!trial[33]) begin
            rem <= trial[32:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= {rem[31:0], quo[31]};
            quo <= {quo[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table plus restart,
// priority and reset-abort sequences.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int checks   = 0;
  int failures = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Start an operation on the next edge, then watch lat+3 cycles for the RDY pulse.
  task automatic run_op(input string name, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] exp_res, input logic exp_exc);
    int          first;
    int          n_rdy;
    logic [31:0] res;
    logic        exc;
    first = -1;
    n_rdy = 0;
    res   = '0;
    exc   = 1'b0;
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    check({name, "_start_clear"}, {31'd0, data_resultRDY, data_exception, data_result}, 64'd0);
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    for (int k = 1; k <= lat + 3; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        if (first < 0) begin
          first = k;
          res   = data_result;
          exc   = data_exception;
        end
        n_rdy++;
      end
    end
    check({name, "_latency"}, 64'(first), 64'(lat));
    check({name, "_rdy_count"}, 64'(n_rdy), 64'd1);
    check({name, "_result"}, {32'd0, res}, {32'd0, exp_res});
    check({name, "_exception"}, {63'd0, exc}, {63'd0, exp_exc});
    check({name, "_hold"}, {31'd0, data_resultRDY, data_exception, data_result},
          {31'd0, 1'b0, exp_exc, exp_res});
  endtask

  initial begin
    int          first;
    int          n_rdy;
    int          bad;
    logic [31:0] res;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[2]  = '{1'b0, 32'h40000000, 32'd2,        32'h80000000, 1'b1};
    vecs[3]  = '{1'b0, 32'hFFFF0000, 32'd32768,    32'h80000000, 1'b0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30,       1'b0};
    vecs[5]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1};
    vecs[6]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7]  = '{1'b0, 32'd0,        32'h12345678, 32'd0,        1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
    vecs[10] = '{1'b1, 32'd5,        32'd0,        32'd0,        1'b1};
    vecs[11] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[12] = '{1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
    vecs[13] = '{1'b1, 32'd7,        32'd7,        32'd1,        1'b0};
    vecs[14] = '{1'b1, 32'hFFFFFFF7, 32'hFFFFFFFD, 32'd3,        1'b0};
    vecs[15] = '{1'b1, 32'd3,        32'd10,       32'd0,        1'b0};

    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {31'd0, data_resultRDY, data_exception, data_result}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_no_rdy", {63'd0, data_resultRDY}, 64'd0);

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), !vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b,
             vecs[i].is_div ? 33 : 17, vecs[i].res, vecs[i].exc);

    // Reset clears a held result.
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("reset_clears_held", {31'd0, data_resultRDY, data_exception, data_result}, 64'd0);
    @(negedge clock); reset = 1'b0;

    run_op("both_high", 1'b1, 1'b1, 32'd6, 32'hFFFFFFFE, 17, 32'hFFFFFFF4, 1'b0);

    // Multiply aborted by a divide start at cycle 5.
    first = -1; n_rdy = 0; res = '0;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'h1234; data_operandB = 32'd5;
    @(posedge clock);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = (k == 5);
      if (k == 5) begin
        data_operandA = 32'd9; data_operandB = 32'd3;
      end else begin
        data_operandA = $urandom; data_operandB = $urandom;
      end
      @(posedge clock); #1;
      if (data_resultRDY) begin
        if (first < 0) begin
          first = k;
          res   = data_result;
        end
        n_rdy++;
      end
    end
    check("restart_latency", 64'(first), 64'd38);
    check("restart_rdy_count", 64'(n_rdy), 64'd1);
    check("restart_result", {32'd0, res}, 64'd3);

    // Divide aborted by reset at cycle 10: never completes.
    bad = 0; n_rdy = 0;
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd7;
    @(posedge clock);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      reset    = (k == 10);
      @(posedge clock); #1;
      if (data_resultRDY) n_rdy++;
      if (k >= 10 && (data_resultRDY || data_exception || data_result != 32'd0)) bad++;
    end
    @(negedge clock); reset = 1'b0;
    check("reset_abort_no_rdy", 64'(n_rdy), 64'd0);
    check("reset_abort_outputs", 64'(bad), 64'd0);
    run_op("after_reset", 1'b1, 1'b0, 32'd6, 32'd7, 17, 32'd42, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
